// File: rtl/pc_sequencer.sv
// Program-counter unit: owns PC and EPC, selects the next PC from sequential,
// branch, jump, jump-register, exception and exception-return sources.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0180
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_offset,
  input  logic        i_jump,
  input  logic [25:0] i_jump_index,
  input  logic        i_jr,
  input  logic [31:0] i_jr_addr,
  input  logic        i_exception,
  input  logic        i_eret,
  input  logic        i_halt,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_plus4,
  output logic [31:0] o_epc,
  output logic        o_halted
);

  typedef enum logic {RUN, HALT} state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] epc, epc_next;
  logic [31:0] pc_plus4;
  logic        exc;

  assign pc_plus4 = pc + 32'd4;
  // A misaligned register jump is reported as an exception, not followed.
  assign exc = i_exception | (i_jr & (i_jr_addr[1:0] != 2'b00));

  always_comb begin
    state_next = state;
    pc_next    = pc;
    epc_next   = epc;
    if (state == RUN) begin
      if (exc) begin
        pc_next  = EXC_VECTOR;
        epc_next = pc;
      end else if (i_halt) begin
        state_next = HALT;
      end else if (i_stall) begin
        pc_next = pc;
      end else if (i_eret) begin
        pc_next = epc;
      end else if (i_jr) begin
        pc_next = i_jr_addr;
      end else if (i_jump) begin
        pc_next = {pc_plus4[31:28], i_jump_index, 2'b00};
      end else if (i_branch_taken) begin
        pc_next = pc_plus4 + (i_branch_offset << 2);
      end else begin
        pc_next = pc_plus4;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= RUN;
      pc    <= RESET_VECTOR;
      epc   <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      epc   <= epc_next;
    end
  end

  assign o_pc       = pc;
  assign o_pc_plus4 = pc_plus4;
  assign o_epc      = epc;
  assign o_halted   = (state == HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios followed by random
// control traffic, both compared against a behavioural next-PC model.
module tb_pc_sequencer;

  localparam logic [31:0] RV  = 32'h0000_0000;
  localparam logic [31:0] EXV = 32'h0000_0180;

  logic        clk = 1'b0;
  logic        rst, stall, branch_taken, jump, jr, exception, eret, halt;
  logic [31:0] branch_offset, jr_addr;
  logic [25:0] jump_index;
  logic [31:0] pc, pc_plus4, epc;
  logic        halted;

  int unsigned checks = 0;
  int unsigned failures = 0;

  // Reference state
  logic [31:0] m_pc, m_epc;
  logic        m_halted;

  always #5 clk = ~clk;

  pc_sequencer #(.RESET_VECTOR(RV), .EXC_VECTOR(EXV)) dut (
    .i_clk(clk), .i_rst(rst), .i_stall(stall),
    .i_branch_taken(branch_taken), .i_branch_offset(branch_offset),
    .i_jump(jump), .i_jump_index(jump_index),
    .i_jr(jr), .i_jr_addr(jr_addr),
    .i_exception(exception), .i_eret(eret), .i_halt(halt),
    .o_pc(pc), .o_pc_plus4(pc_plus4), .o_epc(epc), .o_halted(halted)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    rst = 0; stall = 0; branch_taken = 0; jump = 0; jr = 0;
    exception = 0; eret = 0; halt = 0;
    branch_offset = '0; jr_addr = '0; jump_index = '0;
  endtask

  // Architectural effect of one cycle, written from the priority rules.
  task automatic model_update();
    logic misaligned;
    misaligned = jr && (jr_addr % 4 != 0);
    if (rst) begin
      m_pc = RV; m_epc = 0; m_halted = 0;
    end else if (!m_halted) begin
      if (exception || misaligned) begin
        m_epc = m_pc; m_pc = EXV;
      end else if (halt) m_halted = 1;
      else if (stall) m_pc = m_pc;
      else if (eret) m_pc = m_epc;
      else if (jr) m_pc = jr_addr;
      else if (jump) m_pc = ((m_pc + 32'd4) & 32'hF000_0000) + {6'd0, jump_index} * 32'd4;
      else if (branch_taken) m_pc = m_pc + 32'd4 + branch_offset * 32'd4;
      else m_pc = m_pc + 32'd4;
    end
  endtask

  // One clock: apply current inputs, advance model, compare just after the edge.
  task automatic step(input string tag);
    @(posedge clk);
    model_update();
    #1;
    check({tag, ".pc"}, pc, m_pc);
    check({tag, ".pc4"}, pc_plus4, m_pc + 32'd4);
    check({tag, ".epc"}, epc, m_epc);
    check({tag, ".halted"}, {31'd0, halted}, {31'd0, m_halted});
    idle_inputs();
  endtask

  task automatic goto_pc(input logic [31:0] a);
    jr = 1; jr_addr = a; step("goto");
  endtask

  initial begin
    m_pc = '0; m_epc = '0; m_halted = 0;
    idle_inputs();
    #2;

    rst = 1; step("reset");
    check("reset_pc", pc, 32'h0);
    check("reset_epc", epc, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      step("seq");
      check("seq_pc", pc, 32'(4 * i));
    end

    goto_pc(32'h100);
    branch_taken = 1; branch_offset = 32'hFFFF_FFFE; step("branch");
    check("branch_back", pc, 32'h0FC);
    jump = 1; jump_index = 26'h40; step("jump");
    check("jump", pc, 32'h100);
    jr = 1; jr_addr = 32'h200; step("jr");
    check("jr", pc, 32'h200);
    step("idle");
    jr = 1; jr_addr = 32'h203; stall = 1; step("jr_misaligned");
    check("exc_pc", pc, 32'h180);
    check("exc_epc", epc, 32'h204);
    eret = 1; step("eret");
    check("eret_pc", pc, 32'h204);
    eret = 1; exception = 1; step("eret_exc");
    check("eret_exc_epc", epc, 32'h204);
    goto_pc(32'h208);
    eret = 1; stall = 1; step("eret_stall");
    check("eret_stall_pc", pc, 32'h208);

    goto_pc(32'hFFFF_FFFC);
    step("wrap");
    check("wrap_pc", pc, 32'h0);

    goto_pc(32'h10);
    halt = 1; step("halt");
    check("halt_flag", {31'd0, halted}, 32'd1);
    check("halt_pc", pc, 32'h10);
    for (int i = 0; i < 5; i++) begin
      branch_taken = 1; branch_offset = 32'h8; jump = 1; jump_index = 26'h3;
      exception = 1; step("halted_hold");
      check("halted_pc", pc, 32'h10);
    end
    rst = 1; step("reset_from_halt");
    check("unhalt_pc", pc, RV);
    check("unhalt_flag", {31'd0, halted}, 32'd0);

    goto_pc(32'h20);
    halt = 1; exception = 1; step("halt_exc");
    check("halt_exc_pc", pc, 32'h180);
    check("halt_exc_epc", epc, 32'h20);
    check("halt_exc_flag", {31'd0, halted}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      stall = 1; step("stall");
      check("stall_pc", pc, 32'h180);
    end

    rst = 1; halt = 1; exception = 1; step("reset_overrides");

    for (int n = 0; n < 3000; n++) begin
      rst           = ($urandom_range(0, 99) < 2);
      halt          = ($urandom_range(0, 99) < 3);
      exception     = ($urandom_range(0, 99) < 8);
      stall         = ($urandom_range(0, 99) < 15);
      eret          = ($urandom_range(0, 99) < 10);
      jr            = ($urandom_range(0, 99) < 15);
      jump          = ($urandom_range(0, 99) < 15);
      branch_taken  = ($urandom_range(0, 99) < 25);
      jr_addr       = $urandom;
      if ($urandom_range(0, 3) != 0) jr_addr[1:0] = 2'b00;
      jump_index    = 26'($urandom);
      branch_offset = $urandom;
      if ($urandom_range(0, 1) == 1) branch_offset = 32'($signed(8'($urandom)));
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
